// File: rtl/bit_serializer_if.sv
// Parallel-word input handshake for bit_serializer.
// Valid/ready: the producer (master) drives din and din_valid; the
// serializer (slave) drives din_ready. A word transfers on every rising
// clk edge where din_valid && din_ready. din must be stable whenever
// din_valid is high. din_valid must not depend on din_ready.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: loads a WIDTH-bit word over a valid/ready handshake and
// emits it one bit per cycle on d_out/valid_o, MSB or LSB first.
// pause_i stalls emission without losing state. word_done pulses with
// the last bit of each word.
// Optional feature: define BIT_SERIALIZER_SKID_EN to add a one-word holding
// register. With it, the next word is accepted while the current one shifts,
// and words go out back to back with no idle cycle between them.
// Without it, the block accepts words only in IDLE, so there is always one
// valid_o=0 cycle between words.
// Reset is synchronous and active-high on rst.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  bit_serializer_if.slave  in_if,
  input  logic             pause_i,
  output logic             d_out,
  output logic             valid_o,
  output logic             word_done,
  output logic             busy,
  output logic             dbg_state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             d_out_q, d_out_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic             accept;
  logic             out_bit;
  logic             last_bit;
  logic [WIDTH-1:0] sr_shift;

`ifdef BIT_SERIALIZER_SKID_EN
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
`endif

  // Bit order is fixed at elaboration: pick the outgoing bit and the shift direction.
  generate
    if (MSB_FIRST) begin : g_msb
      assign out_bit  = sr_q[WIDTH-1];
      assign sr_shift = {sr_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign out_bit  = sr_q[0];
      assign sr_shift = {1'b0, sr_q[WIDTH-1:1]};
    end
  endgenerate

  // Ready is gated by rst so no word can be accepted on a reset edge.
`ifdef BIT_SERIALIZER_SKID_EN
  assign in_if.din_ready = !hold_full_q && !rst;
`else
  assign in_if.din_ready = (state_q == S_IDLE) && !rst;
`endif

  assign accept   = in_if.din_valid && in_if.din_ready;
  assign last_bit = (cnt_q == LAST_CNT);

  // Next-state, datapath and output computation for the IDLE/SHIFT FSM.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    d_out_d = d_out_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
`ifdef BIT_SERIALIZER_SKID_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // pause_i has no effect here; the first bit appears one edge after accept.
        if (accept) begin
          sr_d    = in_if.din;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
`ifdef BIT_SERIALIZER_SKID_EN
        // A word offered while shifting is parked, paused or not.
        // On the last-bit edge with an empty holder it goes straight
        // to the shift register instead of being parked.
        if (accept && !(last_bit && !pause_i)) begin
          hold_d      = in_if.din;
          hold_full_d = 1'b1;
        end
`endif
        if (!pause_i) begin
          d_out_d = out_bit;
          valid_d = 1'b1;
          sr_d    = sr_shift;
          cnt_d   = cnt_q + 1'b1;
          if (last_bit) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
`ifdef BIT_SERIALIZER_SKID_EN
            // Reload on the edge that emits the last bit, so no gap opens.
            if (hold_full_q) begin
              sr_d        = hold_q;
              hold_full_d = 1'b0;
              state_d     = S_SHIFT;
            end else if (accept) begin
              sr_d    = in_if.din;
              state_d = S_SHIFT;
            end
`endif
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset discards any word in flight or held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      d_out_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef BIT_SERIALIZER_SKID_EN
      hold_q      <= '0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      d_out_q <= d_out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef BIT_SERIALIZER_SKID_EN
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end

  assign d_out       = d_out_q;
  assign valid_o     = valid_q;
  assign word_done   = done_q;
  assign busy        = (state_q == S_SHIFT);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first and an LSB-first instance
// get identical stimulus. Serial bits from the MSB instance are scored against
// an expected-bit queue. Inputs change 1 ns after each rising edge, and the
// outputs are sampled at that same point.
module tb_bit_serializer;

  logic clk = 1'b0;
  logic rst;
  logic pause;

  logic m_d_out, m_valid, m_done, m_busy, m_state;
  logic l_d_out, l_valid, l_done, l_busy, l_state;

  int num_vec = 0;
  int num_err = 0;

  logic [0:0] exp_q[$];

  bit_serializer_if #(.WIDTH(8)) if_m ();
  bit_serializer_if #(.WIDTH(8)) if_l ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk         (clk),
    .rst         (rst),
    .in_if       (if_m),
    .pause_i     (pause),
    .d_out       (m_d_out),
    .valid_o     (m_valid),
    .word_done   (m_done),
    .busy        (m_busy),
    .dbg_state_o (m_state)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk         (clk),
    .rst         (rst),
    .in_if       (if_l),
    .pause_i     (pause),
    .d_out       (l_d_out),
    .valid_o     (l_valid),
    .word_done   (l_done),
    .busy        (l_busy),
    .dbg_state_o (l_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_vec++;
    if (obs !== exp) begin
      num_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    if_m.din_valid = v;
    if_m.din       = d;
    if_l.din_valid = v;
    if_l.din       = d;
  endtask

  // Send one word. If pause_len > 0, pause is held for pause_len cycles after the 2nd bit.
  task automatic send_word(input string tag, input logic [7:0] w, input logic [7:0] exp_m,
                           input logic [7:0] exp_l, input int pause_len);
    logic [7:0] seq_l;
    logic       prev_d;
    int nbits, cycles, gaps, pcnt, bad_done, bad_hold;
    seq_l = '0; nbits = 0; cycles = 1; gaps = 0; pcnt = 0; bad_done = 0; bad_hold = 0;
    for (int i = 7; i >= 0; i--) exp_q.push_back(exp_m[i]);
    drive(1'b1, w);
    step();
    check({tag, "_hs_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_hs_busy"}, 32'(m_busy), 32'd1);
`ifdef BIT_SERIALIZER_SKID_EN
    check({tag, "_hs_ready"}, 32'(if_m.din_ready), 32'd1);
`else
    check({tag, "_hs_ready"}, 32'(if_m.din_ready), 32'd0);
`endif
    drive(1'b0, ~w);
    prev_d = m_d_out;
    for (int c = 0; c < 40 && nbits < 8; c++) begin
      pause = (nbits == 2 && pcnt < pause_len);
      if (pause) pcnt++;
      step();
      cycles++;
      if (m_valid) begin
        if (exp_q.size() == 0) check({tag, "_extra_bit"}, 32'd1, 32'd0);
        else check({tag, "_bit"}, 32'(m_d_out), 32'(exp_q.pop_front()));
        if (m_done !== (nbits == 7)) bad_done++;
        seq_l = {seq_l[6:0], l_d_out};
        nbits++;
      end else begin
        if (nbits > 0) gaps++;
        if (m_done) bad_done++;
        if (m_d_out !== prev_d) bad_hold++;
      end
      prev_d = m_d_out;
    end
    pause = 1'b0;
    check({tag, "_nbits"}, 32'(nbits), 32'd8);
    check({tag, "_lsb_seq"}, 32'(seq_l), 32'(exp_l));
    check({tag, "_cycles"}, 32'(cycles), 32'(9 + pause_len));
    check({tag, "_gaps"}, 32'(gaps), 32'(pause_len));
    check({tag, "_done_bad"}, 32'(bad_done), 32'd0);
    check({tag, "_hold_bad"}, 32'(bad_hold), 32'd0);
    check({tag, "_end_busy"}, 32'(m_busy), 32'd0);
    check({tag, "_end_ready"}, 32'(if_m.din_ready), 32'd1);
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] seq16;
    int acc, cycles, nvalid, gaps, ndone;
    logic hs;

    rst = 1'b1;
    pause = 1'b0;
    drive(1'b0, 8'h00);
    step();
    step();
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_dout", 32'(m_d_out), 32'd0);
    check("rst_ready", 32'(if_m.din_ready), 32'd0);
    check("rst_state", 32'(m_state), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(if_m.din_ready), 32'd1);

    // pause_i is ignored in IDLE.
    pause = 1'b1;
    step();
    step();
    check("idle_pause_valid", 32'(m_valid), 32'd0);
    check("idle_pause_busy", 32'(m_busy), 32'd0);
    pause = 1'b0;

    // B4 MSB-first = 1,0,1,1,0,1,0,0; LSB-first = 0,0,1,0,1,1,0,1 = 8'h2D.
    send_word("b4", 8'hB4, 8'hB4, 8'h2D, 0);
    // 28 MSB-first = 0,0,1,0,1,0,0,0; LSB-first = 0,0,0,1,0,1,0,0 = 8'h14.
    send_word("w28", 8'h28, 8'h28, 8'h14, 0);
    // B4 with a 3-cycle pause after the 2nd bit.
    send_word("pause", 8'hB4, 8'hB4, 8'h2D, 3);

    // Back-to-back FF then 00, din_valid held high.
    acc = 0; cycles = 0; nvalid = 0; gaps = 0; ndone = 0; seq16 = '0;
    drive(1'b1, 8'hFF);
    for (int c = 0; c < 40 && nvalid < 16; c++) begin
      hs = if_m.din_valid && if_m.din_ready;
      step();
      cycles++;
      if (hs) begin
        acc++;
        if (acc == 1) drive(1'b1, 8'h00);
        else drive(1'b0, 8'h00);
      end
      if (m_valid) begin
        seq16 = {seq16[14:0], m_d_out};
        nvalid++;
        if (m_done) ndone++;
      end else if (nvalid > 0) begin
        gaps++;
      end
    end
    drive(1'b0, 8'h00);
    check("b2b_seq", 32'(seq16), 32'h0000FF00);
    check("b2b_nvalid", 32'(nvalid), 32'd16);
    check("b2b_accepts", 32'(acc), 32'd2);
    check("b2b_done", 32'(ndone), 32'd2);
`ifdef BIT_SERIALIZER_SKID_EN
    check("b2b_cycles", 32'(cycles), 32'd17);
    check("b2b_gaps", 32'(gaps), 32'd0);
`else
    check("b2b_cycles", 32'(cycles), 32'd18);
    check("b2b_gaps", 32'(gaps), 32'd1);
`endif
    step();

    // Reset after the 4th bit of A5 drops the word; 3C must then come out whole.
    drive(1'b1, 8'hA5);
    step();
    drive(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      check("a5_bit_valid", 32'(m_valid), 32'd1);
    end
    rst = 1'b1;
    step();
    check("midrst_valid", 32'(m_valid), 32'd0);
    check("midrst_busy", 32'(m_busy), 32'd0);
    check("midrst_done", 32'(m_done), 32'd0);
    check("midrst_dout", 32'(m_d_out), 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_ready", 32'(if_m.din_ready), 32'd1);
    step();
    check("midrst_idle_valid", 32'(m_valid), 32'd0);
    check("midrst_idle_done", 32'(m_done), 32'd0);
    // 3C = 0011_1100; LSB-first = 0,0,1,1,1,1,0,0 = 8'h3C.
    send_word("w3c", 8'h3C, 8'h3C, 8'h3C, 0);

    $display("== %0d vectors applied, %0d miscompares ==", num_vec, num_err);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, sets the parallel word width in bits; legal range is 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  din is valid this cycle.
REQ-007 din_ready  output  1  block can accept a word; the handshake completes on an edge where din_valid && din_ready.
REQ-008 pause_i  input  1  stall request; while high, no bit is emitted.
REQ-009 d_out  output  1  serial data bit, registered.
REQ-010 valid_o  output  1  d_out carries a valid bit this cycle, registered.
REQ-011 word_done  output  1  one-cycle pulse, coincident with the last bit of each word on d_out/valid_o.
REQ-012 busy  output  1  high while a word is loaded and not yet fully emitted.

Function
REQ-013 The block shall implement a two-state FSM: IDLE (no word held) and SHIFT (word in shift register, bit counter cnt 0..WIDTH-1).
REQ-014 In IDLE, a handshake shall load din into the shift register, clear cnt and move to SHIFT; valid_o stays 0 on that edge.
REQ-015 In SHIFT, on each edge with pause_i=0, the block shall register the next bit onto d_out, set valid_o=1 and increment cnt; first bit appears on the edge after acceptance (1-cycle latency).
REQ-016 In SHIFT, on each edge with pause_i=1, the block shall set valid_o=0, hold d_out, and leave cnt and the shift register unchanged.
REQ-017 The edge that emits bit cnt=WIDTH-1 shall set word_done=1; word_done shall be 0 on all other edges, including paused ones.
REQ-018 pause_i shall be ignored in IDLE; in IDLE valid_o=0 and word_done=0.
REQ-019 Without the Configuration feature, din_ready shall equal (state==IDLE) && !rst; after the last bit the FSM returns to IDLE, giving at least one valid_o=0 cycle between words (WIDTH+1 cycles per word minimum).
REQ-020 busy shall be 1 exactly when state==SHIFT.
REQ-021 din is sampled only on the handshake edge; changes to din at any other time shall have no effect.

Reset
REQ-022 While rst=1: state=IDLE, cnt=0, d_out=0, valid_o=0, word_done=0, busy=0, din_ready=0, and the holding register is empty.
REQ-023 rst asserted mid-word shall discard that word and any held word with no word_done pulse; the first cycle after rst deasserts shall have din_ready=1.

Configuration
REQ-024 Macro BIT_SERIALIZER_SKID_EN, when defined, shall add a one-word holding register; when undefined, the block shall behave exactly per REQ-019.
REQ-025 With BIT_SERIALIZER_SKID_EN: din_ready = !hold_full && !rst; a handshake in IDLE loads the shift register; a handshake in SHIFT loads the holding register.
REQ-026 With BIT_SERIALIZER_SKID_EN, on the last-bit edge: if hold_full, the shift register shall load from the holding register, cnt shall clear and state shall stay SHIFT; if a handshake happens on that same edge with the holding register empty, din shall load directly into the shift register. Either way there is no valid_o gap (WIDTH cycles per word).
REQ-027 With BIT_SERIALIZER_SKID_EN, a paused last bit shall not trigger the reload; the reload occurs on the edge that actually emits that bit.

Verification
REQ-028 WIDTH=8, MSB_FIRST=1, din=8'hB4 accepted -> d_out 1,0,1,1,0,1,0,0 on 8 consecutive valid_o cycles starting one edge after the handshake; word_done only with the final 0.
REQ-029 MSB_FIRST=0, din=8'h28 -> d_out 0,0,0,1,0,1,0,0; MSB_FIRST=1, din=8'h28 -> 0,0,1,0,1,0,0,0 (contains the 0,0,1,0,1 sub-sequence a downstream detector must flag).
REQ-030 pause_i high for 3 cycles after the 2nd bit -> valid_o=0 for exactly those 3 cycles, d_out held, remaining 6 bits follow unchanged, word_done still on the 8th bit.
REQ-031 Two back-to-back words 8'hFF, 8'h00 with din_valid held high -> macro undefined: one valid_o=0 cycle between words, 18 cycles total; macro defined: 16 contiguous valid_o cycles.
REQ-032 rst pulsed after the 4th bit of 8'hA5 -> valid_o=0, busy=0, no word_done; next word 8'h3C serializes correctly from its first bit.
